// File: rtl/uart_host_bus_master_pkg.sv
// Shared definitions for the 8251-style host bus master: FSM states,
// C_nD encodings, default mode byte and the per-access request bundle.
package uart_host_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } bus_st_e;

  localparam logic       C_NDATA       = 1'b0;
  localparam logic       C_NCTRL       = 1'b1;
  localparam logic [7:0] DEF_MODE_WORD = 8'h3F;

  typedef struct packed {
    logic       rd;
    logic       cnd;
    logic [7:0] data;
  } bus_req_t;

endpackage

// File: rtl/uart_host_bus_master_cycle.sv
// Timing counter for one CPU-port access: SETUP, STROBE_CYC strobe cycles,
// HOLD, then RECOV_CYC recovery cycles. Drives the registered bus strobes.
module uart_host_bus_master_cycle
  import uart_host_bus_master_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int RECOV_CYC  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_is_read,
  output logic o_ncs,
  output logic o_nrd,
  output logic o_nwr,
  output logic o_strobe_last,
  output logic o_sample,
  output logic o_done
);

  localparam int CW = $clog2(STROBE_CYC + RECOV_CYC + 2);
  localparam logic [CW-1:0] L_STB  = CW'(STROBE_CYC);
  localparam logic [CW-1:0] L_HOLD = CW'(STROBE_CYC + 1);
  localparam logic [CW-1:0] L_LAST = CW'(STROBE_CYC + RECOV_CYC + 1);

  logic          r_busy, r_read, r_ncs, r_nrd, r_nwr;
  logic [CW-1:0] r_cnt;
  logic          w_busy_nxt, w_read_nxt, w_in_cs, w_in_stb;
  logic [CW-1:0] w_cnt_nxt;

  // Cycle index 0 = SETUP, 1..STROBE_CYC = strobe, then HOLD, then recovery.
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = r_cnt;
    w_read_nxt = r_read;
    if (i_start) begin
      w_busy_nxt = 1'b1;
      w_cnt_nxt  = '0;
      w_read_nxt = i_is_read;
    end else if (r_busy) begin
      if (r_cnt == L_LAST) w_busy_nxt = 1'b0;
      else                 w_cnt_nxt  = r_cnt + CW'(1);
    end
    w_in_cs  = w_busy_nxt && (w_cnt_nxt <= L_HOLD);
    w_in_stb = w_busy_nxt && (w_cnt_nxt != '0) && (w_cnt_nxt <= L_STB);
  end

  // Strobes are registered from next-state so the bus never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_read <= 1'b0;
      r_ncs  <= 1'b1;
      r_nrd  <= 1'b1;
      r_nwr  <= 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
      r_read <= w_read_nxt;
      r_ncs  <= !w_in_cs;
      r_nrd  <= !(w_in_stb && w_read_nxt);
      r_nwr  <= !(w_in_stb && !w_read_nxt);
    end
  end

  assign o_ncs         = r_ncs;
  assign o_nrd         = r_nrd;
  assign o_nwr         = r_nwr;
  assign o_strobe_last = r_busy && (r_cnt == L_STB);
  assign o_sample      = o_strobe_last && r_read;
  assign o_done        = r_busy && (r_cnt == L_LAST);

endmodule

// File: rtl/uart_host_bus_master.sv
// Host-side initiator for an 8251-style CPU port: writes the mode byte after
// reset, then arbitrates command writes, RX reads and TX writes onto the bus.
module uart_host_bus_master
  import uart_host_bus_master_pkg::*;
#(
  parameter logic [7:0] MODE_WORD  = DEF_MODE_WORD,
  parameter int         STROBE_CYC = 2,
  parameter int         RECOV_CYC  = 4
) (
  input  logic       CLK50M,
  input  logic       n_RST,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done,
  output logic [7:0] bus_dout,
  input  logic [7:0] bus_din,
  output logic       n_CS,
  output logic       C_nD,
  output logic       n_RD,
  output logic       n_WR,
  input  logic       Tx_RDY,
  input  logic       Rx_RDY,
  input  logic       n_INT
);

  bus_st_e    r_st, w_st_nxt;
  bus_req_t   w_req;
  logic       w_start, w_strobe_last, w_sample, w_done;
  logic       r_tx_rdy, r_rx_rdy, r_nint_dbg_unused;
  logic       r_cnd, r_is_init, r_rx_valid, r_init_done;
  logic [7:0] r_dout, r_rx_data;

  always_ff @(posedge CLK50M or negedge n_RST) begin
    if (!n_RST) r_st <= ST_INIT;
    else        r_st <= w_st_nxt;
  end

  // Fixed priority in IDLE: command, then read, then TX write.
  always_comb begin
    w_st_nxt  = r_st;
    w_start   = 1'b0;
    w_req     = '{rd: 1'b0, cnd: C_NCTRL, data: r_dout};
    cmd_ready = 1'b0;
    tx_ready  = 1'b0;
    case (r_st)
      ST_INIT: begin
        w_start  = 1'b1;
        w_req    = '{rd: 1'b0, cnd: C_NCTRL, data: MODE_WORD};
        w_st_nxt = ST_SETUP;
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          w_start   = 1'b1;
          w_req     = '{rd: 1'b0, cnd: C_NCTRL, data: cmd_data};
          cmd_ready = 1'b1;
        end else if (r_rx_rdy && (!r_rx_valid || rx_ready)) begin
          w_start   = 1'b1;
          w_req.rd  = 1'b1;
          w_req.cnd = C_NDATA;
        end else if (r_tx_rdy && tx_valid) begin
          w_start   = 1'b1;
          w_req     = '{rd: 1'b0, cnd: C_NDATA, data: tx_data};
          tx_ready  = 1'b1;
        end
        if (w_start) w_st_nxt = ST_SETUP;
      end
      ST_SETUP:   w_st_nxt = ST_STROBE;
      ST_STROBE:  if (w_strobe_last) w_st_nxt = ST_HOLD;
      ST_HOLD:    w_st_nxt = ST_RECOVER;
      ST_RECOVER: if (w_done) w_st_nxt = ST_IDLE;
      default:    w_st_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK50M or negedge n_RST) begin
    if (!n_RST) begin
      r_tx_rdy          <= 1'b0;
      r_rx_rdy          <= 1'b0;
      r_nint_dbg_unused <= 1'b1;
      r_cnd             <= C_NCTRL;
      r_dout            <= 8'h00;
      r_is_init         <= 1'b0;
      r_init_done       <= 1'b0;
      r_rx_data         <= 8'h00;
      r_rx_valid        <= 1'b0;
    end else begin
      r_tx_rdy          <= Tx_RDY;
      r_rx_rdy          <= Rx_RDY;
      r_nint_dbg_unused <= n_INT;
      if (w_start) begin
        r_cnd     <= w_req.cnd;
        r_dout    <= w_req.data;
        r_is_init <= (r_st == ST_INIT);
      end
      if (r_st == ST_HOLD && r_is_init) r_init_done <= 1'b1;
      // rx_data is only written when empty, so a pending byte is never overwritten.
      if (w_sample) begin
        r_rx_data  <= bus_din;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  uart_host_bus_master_cycle #(
    .STROBE_CYC(STROBE_CYC),
    .RECOV_CYC (RECOV_CYC)
  ) u_cycle (
    .clk          (CLK50M),
    .rst_n        (n_RST),
    .i_start      (w_start),
    .i_is_read    (w_req.rd),
    .o_ncs        (n_CS),
    .o_nrd        (n_RD),
    .o_nwr        (n_WR),
    .o_strobe_last(w_strobe_last),
    .o_sample     (w_sample),
    .o_done       (w_done)
  );

  assign C_nD      = r_cnd;
  assign bus_dout  = r_dout;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign init_done = r_init_done;

endmodule
